// File: rtl/pattern_loader_if.sv
// Pattern-buffer shift bus: byte input stream, serial strobe/data pair and readback byte stream.
// The master side is the loader; the slave side is the byte source, buffer and readback consumer.
interface pattern_loader_if #(
    parameter int BUF_WIDTH = 8
);
    logic [BUF_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 ssel;
    logic                 sin;
    logic                 sout;
    logic [BUF_WIDTH-1:0] rd_data;
    logic                 rd_valid;

    modport master (
        input  in_data, in_valid, sout,
        output in_ready, ssel, sin, rd_data, rd_valid
    );

    modport slave (
        output in_data, in_valid, sout,
        input  in_ready, ssel, sin, rd_data, rd_valid
    );
endinterface

// File: rtl/pattern_loader.sv
// Serial master for the pattern buffer: shifts BUF_SIZE bytes MSB-first on sin with one ssel
// pulse per bit, while reassembling the displaced old contents from sout into readback bytes.
module pattern_loader #(
    parameter int BUF_SIZE   = 22,
    parameter int BUF_WIDTH  = 8,
    parameter int STROBE_GAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    pattern_loader_if.master  bus,
    output logic              busy,
    output logic              done
);
    localparam int BYTE_W = (BUF_SIZE > 1)   ? $clog2(BUF_SIZE)   : 1;
    localparam int BIT_W  = (BUF_WIDTH > 1)  ? $clog2(BUF_WIDTH)  : 1;
    localparam int GAP_W  = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BUF_SIZE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BUF_WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STROBE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT_HI,
        SHIFT_LO
    } state_t;

    state_t               state;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [BUF_WIDTH-1:0] tx_shift;
    logic [BUF_WIDTH-1:0] rx_shift;
    logic [BUF_WIDTH-1:0] rd_data_q;
    logic                 rd_valid_q;
    logic                 ssel_q;
    logic                 sin_q;

    assign bus.in_ready = (state == WAIT_BYTE);
    assign bus.ssel     = ssel_q;
    assign bus.sin      = sin_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    // sin is only updated on the edge that raises ssel, so it is stable for the whole high
    // cycle. tx_shift rotates rather than shifts; the wrapped bit is never presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ssel_q     <= 1'b0;
            sin_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= WAIT_BYTE;
                    end
                end
                WAIT_BYTE: begin
                    if (bus.in_valid) begin
                        tx_shift <= bus.in_data;
                        bit_cnt  <= '0;
                        ssel_q   <= 1'b1;
                        sin_q    <= bus.in_data[BUF_WIDTH-1];
                        state    <= SHIFT_HI;
                    end
                end
                // The buffer shifts on this same edge, so sout still shows the pre-shift bit.
                SHIFT_HI: begin
                    ssel_q   <= 1'b0;
                    rx_shift <= {rx_shift[BUF_WIDTH-2:0], bus.sout};
                    gap_cnt  <= '0;
                    state    <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (bit_cnt != BIT_LAST) begin
                        tx_shift <= {tx_shift[BUF_WIDTH-2:0], tx_shift[BUF_WIDTH-1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        ssel_q   <= 1'b1;
                        sin_q    <= tx_shift[BUF_WIDTH-2];
                        state    <= SHIFT_HI;
                    end else begin
                        rd_data_q  <= rx_shift;
                        rd_valid_q <= 1'b1;
                        if (byte_cnt != BYTE_LAST) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= WAIT_BYTE;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: a shift-register model of the pattern buffer hangs off the
// default instance; a second STROBE_GAP=3 instance checks the strobe spacing.
module tb_pattern_loader;
    localparam int BUF_SIZE  = 22;
    localparam int BUF_WIDTH = 8;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic start3;
    logic busy3;
    logic done3;

    pattern_loader_if #(.BUF_WIDTH(BUF_WIDTH)) bus ();
    pattern_loader_if #(.BUF_WIDTH(BUF_WIDTH)) bus3 ();

    pattern_loader #(.BUF_SIZE(BUF_SIZE), .BUF_WIDTH(BUF_WIDTH), .STROBE_GAP(1)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    pattern_loader #(.BUF_SIZE(2), .BUF_WIDTH(BUF_WIDTH), .STROBE_GAP(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .start (start3),
        .bus   (bus3),
        .busy  (busy3),
        .done  (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0] buf_mem [BUF_SIZE];
    bit       preload_en = 1'b0;
    bit [7:0] preload_base = 8'h00;
    logic     ssel_prev = 1'b0;
    int       cyc = 0;
    int       pulse_cnt = 0;
    int       dbl_cnt = 0;
    int       wait_ssel_cnt = 0;
    int       done_cnt = 0;
    int       rd_cnt = 0;
    logic [7:0] rd_log [256];
    int       p3 = 0;
    int       low_run3 = 0;
    logic     sin_log3 [16];
    int       gap_log3 [16];

    assign bus.sout  = buf_mem[BUF_SIZE-1][7];
    assign bus3.sout = 1'b0;

    // Buffer model shifts on each ssel rising edge; also tallies strobe and handshake events.
    always @(posedge clk) begin
        cyc++;
        if (preload_en) begin
            for (int k = 0; k < BUF_SIZE; k++) buf_mem[k] <= preload_base + 8'(k);
        end else if (bus.ssel && !ssel_prev) begin
            for (int k = BUF_SIZE - 1; k > 0; k--) buf_mem[k] <= {buf_mem[k][6:0], buf_mem[k-1][7]};
            buf_mem[0] <= {buf_mem[0][6:0], bus.sin};
        end
        if (bus.ssel) pulse_cnt++;
        if (bus.ssel && ssel_prev) dbl_cnt++;
        if (bus.ssel && bus.in_ready) wait_ssel_cnt++;
        if (done) done_cnt++;
        if (bus.rd_valid) begin
            if (rd_cnt < 256) rd_log[rd_cnt] = bus.rd_data;
            rd_cnt++;
        end
        ssel_prev <= bus.ssel;
        if (bus3.ssel) begin
            if (p3 < 16) begin
                sin_log3[p3] = bus3.sin;
                gap_log3[p3] = low_run3;
            end
            p3++;
            low_run3 = 0;
        end else begin
            low_run3++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Buffer must hold the bytes of a base-0x00 load: first byte accepted lands in the top slot.
    task automatic check_buffer(input string tag);
        int mism;
        mism = 0;
        for (int k = 0; k < BUF_SIZE; k++)
            if (buf_mem[k] !== 8'(BUF_SIZE - 1 - k)) mism++;
        check_output(tag, mism, 0);
    endtask

    // Runs one load, feeding base+n on the n-th accepted byte; cycles is measured from the first
    // WAIT_BYTE cycle to the done pulse, -1 on timeout, -2 when aborted at cycle abort_at.
    task automatic apply_load(input logic [7:0] base, input int throttle, input int start_at,
                              input int abort_at, output int cycles);
        int   idx;
        int   c0;
        logic acc;
        idx          = 0;
        cycles       = -1;
        bus.in_data  = base;
        bus.in_valid = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        c0    = cyc;
        for (int i = 0; i < 4000; i++) begin
            if (i == abort_at) begin
                cycles = -2;
                break;
            end
            acc   = bus.in_valid && bus.in_ready;
            start = (i == start_at);
            tick();
            start = 1'b0;
            if (acc) begin
                idx++;
                bus.in_data = base + 8'(idx);
            end
            bus.in_valid = (throttle <= 1) || (((i + 1) % throttle) == 0);
            if (done) begin
                cycles = cyc - c0;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int cycles;
        int p0;
        int d0;
        int r0;
        int c0;
        int cycles3;
        int bad;
        logic [7:0] pat;

        reset        = 1'b1;
        start        = 1'b0;
        start3       = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus3.in_data = 8'h81;
        bus3.in_valid = 1'b0;
        idle(2);
        check_output("rst_ssel", bus.ssel, 1'b0);
        check_output("rst_sin", bus.sin, 1'b0);
        check_output("rst_in_ready", bus.in_ready, 1'b0);
        check_output("rst_rd_valid", bus.rd_valid, 1'b0);
        check_output("rst_rd_data", bus.rd_data, 8'h00);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        reset = 1'b0;
        idle(2);

        $display("[TB] scenario 1: full load, in_valid held high");
        preload_base = 8'h00;
        preload_en   = 1'b1;
        tick();
        preload_en = 1'b0;
        p0 = pulse_cnt; d0 = done_cnt; r0 = rd_cnt;
        apply_load(8'h00, 1, -1, -1, cycles);
        check_output("s1_busy_at_done", busy, 1'b0);
        idle(5);
        check_output("s1_cycles", cycles, 374);
        check_output("s1_pulses", pulse_cnt - p0, 176);
        check_output("s1_ssel_double_high", dbl_cnt, 0);
        check_output("s1_done_count", done_cnt - d0, 1);
        check_output("s1_rd_count", rd_cnt - r0, 22);
        check_output("s1_buf_byte21", buf_mem[21], 8'h00);
        check_output("s1_buf_byte0", buf_mem[0], 8'h15);

        $display("[TB] scenario 2: readback of preloaded buffer");
        preload_base = 8'hA0;
        preload_en   = 1'b1;
        tick();
        preload_en = 1'b0;
        r0 = rd_cnt;
        apply_load(8'h00, 1, -1, -1, cycles);
        idle(5);
        check_output("s2_cycles", cycles, 374);
        check_output("s2_rd_count", rd_cnt - r0, 22);
        for (int j = 0; j < BUF_SIZE; j++)
            check_output($sformatf("s2_rd_data_%0d", j), rd_log[r0 + j], 8'hB5 - 8'(j));

        $display("[TB] scenario 3: throttled in_valid");
        preload_base = 8'hA0;
        preload_en   = 1'b1;
        tick();
        preload_en = 1'b0;
        p0 = pulse_cnt;
        apply_load(8'h00, 5, -1, -1, cycles);
        idle(5);
        check_output("s3_finished", cycles >= 374, 1'b1);
        check_output("s3_pulses", pulse_cnt - p0, 176);
        check_output("s3_ssel_in_wait", wait_ssel_cnt, 0);
        check_output("s3_ssel_double_high", dbl_cnt, 0);
        check_buffer("s3_buffer");

        $display("[TB] scenario 4: STROBE_GAP=3 with byte 0x81");
        bus3.in_valid = 1'b1;
        start3        = 1'b1;
        tick();
        start3  = 1'b0;
        c0      = cyc;
        cycles3 = -1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (done3) begin
                cycles3 = cyc - c0;
                break;
            end
        end
        bus3.in_valid = 1'b0;
        idle(3);
        check_output("s4_cycles_2_bytes", cycles3, 66);
        check_output("s4_pulses", p3, 16);
        pat = '0;
        for (int b = 0; b < 8; b++) pat[7-b] = sin_log3[b];
        check_output("s4_sin_pattern", pat, 8'h81);
        bad = 0;
        for (int b = 1; b < 8; b++) if (gap_log3[b] != 3) bad++;
        check_output("s4_gap_lengths", bad, 0);

        $display("[TB] scenario 5: reset at bit 5 of byte 10");
        apply_load(8'h40, 1, -1, 181, cycles);
        check_output("s5_aborted", cycles, 32'hFFFF_FFFE);
        check_output("s5_pre_ssel", bus.ssel, 1'b1);
        check_output("s5_pre_busy", busy, 1'b1);
        d0    = done_cnt;
        reset = 1'b1;
        #1;
        check_output("s5_async_ssel", bus.ssel, 1'b0);
        check_output("s5_async_busy", busy, 1'b0);
        check_output("s5_async_in_ready", bus.in_ready, 1'b0);
        idle(3);
        reset = 1'b0;
        idle(3);
        check_output("s5_no_done", done_cnt - d0, 0);
        check_output("s5_idle_busy", busy, 1'b0);
        apply_load(8'h00, 1, -1, -1, cycles);
        idle(5);
        check_output("s5_reload_cycles", cycles, 374);
        check_buffer("s5_reload_buffer");

        $display("[TB] scenario 6: start pulse during an active load");
        p0 = pulse_cnt; d0 = done_cnt;
        apply_load(8'h00, 1, 50, -1, cycles);
        idle(20);
        check_output("s6_cycles", cycles, 374);
        check_output("s6_pulses", pulse_cnt - p0, 176);
        check_output("s6_done_count", done_cnt - d0, 1);
        check_output("s6_busy_after", busy, 1'b0);
        check_output("s6_ssel_double_high", dbl_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
Serial host-side master for the pattern buffer's shift interface. It accepts pattern bytes over a valid/ready handshake and serialises them MSB-first onto sin, producing one ssel rising edge per bit. At the same time it captures sout to stream the buffer's previous contents back out as bytes, giving a non-destructive-readback path. It sits between the configuration/scan controller and the pattern buffer, and must only run while the PAT core is not issuing field writes.

Parameters:
BUF_SIZE, 22, number of pattern bytes in the target buffer (bytes per load).
BUF_WIDTH, 8, bits per pattern byte.
STROBE_GAP, 1, ssel-low cycles after each ssel-high cycle (min 1).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a full BUF_SIZE-byte load; ignored while busy.
in_data  input  BUF_WIDTH  next pattern byte to shift in.
in_valid  input  1  in_data valid.
in_ready  output  1  byte accepted on cycles where in_valid && in_ready.
ssel  output  1  shift strobe to buffer (registered).
sin  output  1  serial data to buffer (registered).
sout  input  1  serial data from buffer (MSB of last buffer byte).
rd_data  output  BUF_WIDTH  readback byte (old buffer contents).
rd_valid  output  1  one-cycle pulse when rd_data is updated.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse after the last bit's gap completes.

Behaviour:
- Reset (async): state IDLE; ssel=0, sin=0, in_ready=0, rd_data=0, rd_valid=0, busy=0, done=0; byte and bit counters cleared.
- States:
  - IDLE: start -> WAIT_BYTE with byte_cnt=0 and busy=1.
  - WAIT_BYTE: in_ready=1 (combinational from state); hold ssel=0. On in_valid: latch byte into tx_shift, bit_cnt=0 -> SHIFT_HI. No data available = stall indefinitely; this is legal because the buffer shifts only on ssel edges.
  - SHIFT_HI (1 cycle): ssel=1, sin=tx_shift[MSB]. At the closing edge, sample sout into rx_shift LSB. This is the pre-shift bit, since the buffer shifts on the same edge. -> SHIFT_LO.
  - SHIFT_LO (STROBE_GAP cycles, gap counter): ssel=0, sin held. On the final gap cycle:
    - If bit_cnt<BUF_WIDTH-1: shift tx_shift left, bit_cnt++, -> SHIFT_HI.
    - Else: rd_data<=rx_shift, rd_valid=1 for one cycle.
      - If byte_cnt<BUF_SIZE-1: byte_cnt++, -> WAIT_BYTE.
      - Else: done=1 for one cycle, busy=0, -> IDLE.
- ssel is never high on two consecutive cycles. Every ssel high is preceded and followed by at least one low cycle, so the buffer sees exactly one rising edge per bit.
- sin changes only in the cycle ssel rises; it is stable while ssel=1.
- Ordering:
  - The first byte accepted ends in buffer byte BUF_SIZE-1.
  - The last byte accepted ends in byte 0.
  - The first rd_data byte is the old buffer byte BUF_SIZE-1; the last is the old byte 0.
- Timing: bytes per load = BUF_SIZE; bits = BUF_SIZE*BUF_WIDTH.
  - With in_valid held high: cycles per byte = 1 + BUF_WIDTH*(1+STROBE_GAP).
  - Defaults: 17 cycles per byte, 374 cycles from the first WAIT_BYTE cycle to the done pulse.
- start while busy: ignored, no effect on counters.
- rd_valid has no backpressure; the consumer must accept it.
- Reset mid-load: outputs drop to their reset values immediately. The buffer is left partially shifted, with no done pulse; software must restart.
- Counters are sized $clog2 of their ranges. Wrap-around cannot occur; terminal counts are compared explicitly.

Test Plan:
1. Reset, start, feed bytes 0x00..0x15 with in_valid always high, model buffer attached -> 176 ssel pulses, each exactly 1 cycle high, done at cycle 374 after first WAIT_BYTE; buffer byte 21=0x00, byte 0=0x15.
2. Preload model buffer with byte k = 0xA0+k, run a load -> rd_valid 22 times; rd_data sequence 0xB5,0xB4,...,0xA0.
3. Throttle in_valid (high 1 cycle in 5) -> ssel stays low during WAIT_BYTE; final buffer contents identical to scenario 1; no extra ssel edges.
4. STROBE_GAP=3, byte 0x81 -> sin pattern 1,0,0,0,0,0,0,1; each ssel high followed by exactly 3 low cycles; 33 cycles per byte.
5. Assert reset at bit 5 of byte 10 -> ssel=0, busy=0 same cycle (async); no done; fresh start then completes a full 374-cycle load correctly.
6. Pulse start at cycle 50 of an active load -> ignored; exactly 176 ssel pulses and one done.
